// File: rtl/fb_stream_writer_if.sv
`default_nettype none
// ============================================================================
// fb_stream_writer_if : valid/ready RGB888 pixel stream with start-of-frame
// Revision: 1.0
// ============================================================================
interface fb_stream_writer_if;
    logic        s_valid;
    logic        s_ready;
    logic        s_sof;
    logic [23:0] s_data;

    modport master (
        output s_valid,
        output s_sof,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_sof,
        input  s_data,
        output s_ready
    );
endinterface
`default_nettype wire

// File: rtl/fb_stream_writer.sv
`default_nettype none
// ============================================================================
// fb_stream_writer : fills R/G/B framebuffer RAMs from a pixel stream, linear
// addressing, resync on mid-frame SOF. Optional macro: FB_DOUBLE_BUF_EN.
// Revision: 1.0
// ============================================================================
module fb_stream_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fb_stream_writer_if.slave s_if,
    output logic              wr_en_o,
`ifdef FB_DOUBLE_BUF_EN
    output logic [ADDR_W:0]   wr_addr_o,
`else
    output logic [ADDR_W-1:0] wr_addr_o,
`endif
    output logic [7:0]        wr_r_o,
    output logic [7:0]        wr_g_o,
    output logic [7:0]        wr_b_o,
    output logic              frame_done_o,
    output logic              sof_err_o,
    output logic              rd_bank_o
);

    localparam int c_X_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int c_Y_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [c_X_W-1:0] c_X_LAST = c_X_W'(H_ACTIVE - 1);
    localparam logic [c_Y_W-1:0] c_Y_LAST = c_Y_W'(V_ACTIVE - 1);
    localparam bit c_ONE_PIX = (H_ACTIVE * V_ACTIVE == 1);
    // Position following pixel (0,0); differs only for one-pixel-wide lines.
    localparam logic [c_X_W-1:0] c_X_AFTER0 = (H_ACTIVE > 1) ? c_X_W'(1) : '0;
    localparam logic [c_Y_W-1:0] c_Y_AFTER0 = (H_ACTIVE > 1) ? '0 : c_Y_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_X_W-1:0]    x_q, x_d;
    logic [c_Y_W-1:0]    y_q, y_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ready_q, ready_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic [23:0]         pix_q, pix_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                w_acc;

    assign w_acc = s_if.s_valid & ready_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        addr_d  = addr_q;
        wr_en_d = 1'b0;
        wa_d    = wa_q;
        pix_d   = pix_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_acc && s_if.s_sof) begin
                    wr_en_d = 1'b1;
                    wa_d    = '0;
                    pix_d   = s_if.s_data;
                    if (c_ONE_PIX) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        x_d     = c_X_AFTER0;
                        y_d     = c_Y_AFTER0;
                        addr_d  = ADDR_W'(1);
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (w_acc) begin
                    wr_en_d = 1'b1;
                    pix_d   = s_if.s_data;
                    if (s_if.s_sof && (x_q != '0 || y_q != '0)) begin
                        err_d  = 1'b1;
                        wa_d   = '0;
                        x_d    = c_X_AFTER0;
                        y_d    = c_Y_AFTER0;
                        addr_d = ADDR_W'(1);
                    end else begin
                        wa_d = addr_q;
                        if (x_q == c_X_LAST && y_q == c_Y_LAST) begin
                            done_d  = 1'b1;
                            x_d     = '0;
                            y_d     = '0;
                            addr_d  = '0;
                            state_d = ST_DONE;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                            if (x_q == c_X_LAST) begin
                                x_d = '0;
                                y_d = y_q + c_Y_W'(1);
                            end else begin
                                x_d = x_q + c_X_W'(1);
                            end
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Ready is registered, so it must look ahead at the next state.
        ready_d = (state_d != ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
            wa_q    <= '0;
            pix_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            wr_en_q <= wr_en_d;
            wa_q    <= wa_d;
            pix_q   <= pix_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef FB_DOUBLE_BUF_EN
    logic bank_q, bank_d;
    logic wbank_q, wbank_d;

    // Swap only when leaving DONE; aborted frames never reach it.
    always_comb begin
        bank_d  = bank_q ^ (state_q == ST_DONE);
        wbank_d = wr_en_d ? ~bank_q : wbank_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q  <= 1'b0;
            wbank_q <= 1'b0;
        end else begin
            bank_q  <= bank_d;
            wbank_q <= wbank_d;
        end
    end

    assign wr_addr_o = {wbank_q, wa_q};
    assign rd_bank_o = bank_q;
`else
    assign wr_addr_o = wa_q;
    assign rd_bank_o = 1'b0;
`endif

    assign s_if.s_ready = ready_q;
    assign wr_en_o      = wr_en_q;
    assign wr_r_o       = pix_q[23:16];
    assign wr_g_o       = pix_q[15:8];
    assign wr_b_o       = pix_q[7:0];
    assign frame_done_o = done_q;
    assign sof_err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_stream_writer.sv
`default_nettype none
// ============================================================================
// tb_fb_stream_writer : randomized stream stimulus, frame-level reference
// model and write scoreboard for fb_stream_writer (small frame geometry).
// Revision: 1.0
// ============================================================================
module tb_fb_stream_writer;
    localparam int H    = 8;
    localparam int V    = 6;
    localparam int AW   = 6;
    localparam int NPIX = H * V;
`ifdef FB_DOUBLE_BUF_EN
    localparam int WAW = AW + 1;
`else
    localparam int WAW = AW;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_en;
    logic [WAW-1:0] wr_addr;
    logic [7:0]     wr_r, wr_g, wr_b;
    logic           frame_done, sof_err, rd_bank;

    fb_stream_writer_if s_if ();

    fb_stream_writer #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_if         (s_if.slave),
        .wr_en_o      (wr_en),
        .wr_addr_o    (wr_addr),
        .wr_r_o       (wr_r),
        .wr_g_o       (wr_g),
        .wr_b_o       (wr_b),
        .frame_done_o (frame_done),
        .sof_err_o    (sof_err),
        .rd_bank_o    (rd_bank)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WAW-1:0] addr;
        logic [23:0]    data;
        logic           done;
        logic           err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Frame-level model: position as a pixel index, one bubble after each frame.
    bit   in_frame  = 1'b0;
    int   pix       = 0;
    bit   bubble    = 1'b0;
    bit   bank      = 1'b0;
    bit   exp_ready = 1'b0;
    bit   was_rst   = 1'b0;
    bit   last_acc  = 1'b0;
    bit   m_err;
    exp_t m_e;
    exp_t c_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        last_acc = 1'b0;
        if (rst) begin
            in_frame  = 1'b0;
            pix       = 0;
            bubble    = 1'b0;
            bank      = 1'b0;
            exp_ready = 1'b0;
            was_rst   = 1'b1;
        end else begin
            was_rst  = 1'b0;
            last_acc = s_if.s_valid && exp_ready;
            if (bubble) begin
                bubble = 1'b0;
`ifdef FB_DOUBLE_BUF_EN
                bank = ~bank;
`endif
            end
            if (last_acc) begin
                m_err = 1'b0;
                if (s_if.s_sof) begin
                    m_err    = in_frame && (pix != 0);
                    pix      = 0;
                    in_frame = 1'b1;
                end
                if (in_frame) begin
                    m_e.addr = WAW'(pix);
`ifdef FB_DOUBLE_BUF_EN
                    m_e.addr[WAW-1] = ~bank;
`endif
                    m_e.data = s_if.s_data;
                    m_e.done = (pix == NPIX - 1);
                    m_e.err  = m_err;
                    q.push_back(m_e);
                    pix++;
                    if (pix == NPIX) begin
                        in_frame = 1'b0;
                        pix      = 0;
                        bubble   = 1'b1;
                    end
                end
            end
            exp_ready = !bubble;
        end
    end

    always @(negedge clk) begin
        chk("s_ready", 64'(s_if.s_ready), 64'(exp_ready));
        chk("rd_bank", 64'(rd_bank), 64'(bank));
        if (was_rst) begin
            chk("rst_wr_addr", 64'(wr_addr), 64'(0));
            chk("rst_wr_data", 64'({wr_r, wr_g, wr_b}), 64'(0));
        end
        if (wr_en === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_write", 64'(wr_en), 64'(0));
            end else begin
                c_e = q.pop_front();
                chk("wr_addr", 64'(wr_addr), 64'(c_e.addr));
                chk("wr_data", 64'({wr_r, wr_g, wr_b}), 64'(c_e.data));
                chk("frame_done", 64'(frame_done), 64'(c_e.done));
                chk("sof_err", 64'(sof_err), 64'(c_e.err));
            end
        end else begin
            chk("wr_en_idle", 64'(wr_en), 64'(0));
            chk("frame_done_idle", 64'(frame_done), 64'(0));
            chk("sof_err_idle", 64'(sof_err), 64'(0));
        end
    end

    task automatic idle(input int n);
        s_if.s_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Idle cycles carry random sof/data with valid low, which must be ignored.
    task automatic send(input bit sof, input int gap);
        repeat (gap) begin
            s_if.s_valid = 1'b0;
            s_if.s_sof   = 1'($urandom);
            s_if.s_data  = 24'($urandom);
            @(posedge clk);
            #1;
        end
        s_if.s_valid = 1'b1;
        s_if.s_sof   = sof;
        s_if.s_data  = 24'($urandom);
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #1;
            if (last_acc) break;
        end
        if (!last_acc) chk("accept_timeout", 64'(last_acc), 64'(1));
    endtask

    task automatic frame(input int gapmax);
        for (int p = 0; p < NPIX; p++) send(p == 0, $urandom_range(0, gapmax));
    endtask

    initial begin
        s_if.s_valid = 1'b0;
        s_if.s_sof   = 1'b0;
        s_if.s_data  = '0;
        rst          = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;

        frame(0);
        frame(0);
        idle(3);

        for (int i = 0; i < 5; i++) send(1'b0, 0);
        frame(0);
        idle(2);

        for (int p = 0; p < 11 + NPIX; p++) send(p == 0 || p == 11, 0);
        idle(2);

        frame(2);
        idle(2);

        for (int p = 0; p < 20; p++) send(p == 0, 0);
        s_if.s_valid = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(1'b0, 0);
        idle(2);
        frame(0);
        frame(1);

        for (int i = 0; i < 300; i++) send($urandom_range(0, 40) == 0, $urandom_range(0, 1));
        idle(5);

        chk("queue_empty", 64'(q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
